// File: rtl/pwm_pkg.sv
// Purpose : shared state encoding and default sizing for the PWM capture block.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: state_e (SYNC, MEASURE), DEF_CNT_W, DEF_TIMEOUT.
package pwm_pkg;

   typedef enum logic {
      SYNC    = 1'b0,   // waiting for a first rising edge (after reset or timeout)
      MEASURE = 1'b1    // counting a period that began on a rising edge
   } state_e;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/pwm_in_filter.sv
// Purpose : two-flop synchronizer for the asynchronous PWM input, plus an optional glitch filter.
// Latency : 2 cycles; FILTER_LEN more when PWM_CAPTURE_FILTER_EN is defined.
// Backpr. : none, the input is sampled every cycle.
// Ports   : clk_i, rst_n_i (async active-low), din_i (raw PWM), dout_o (clean level).
// Macro   : PWM_CAPTURE_FILTER_EN compiles in the filter and its FILTER_LEN parameter.
module pwm_in_filter
`ifdef PWM_CAPTURE_FILTER_EN
#(
   parameter int FILTER_LEN = 4
)
`endif
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic din_i,
   output logic dout_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din_i;
         s2_q <= s1_q;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   // cnt_q counts consecutive synced samples that disagree with the filtered
   // level; the level flips on the FILTER_LEN-th disagreeing sample.
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == LAST) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o = filt_q;
`else
   assign dout_o = s2_q;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Purpose : measures period and high time of a PWM input in clk_i cycles; flags a stuck input.
// Latency : valid_o rises 3 cycles after the clock edge that first samples pwm_in_i high (+FILTER_LEN with filter).
// Backpr. : none; valid_o is a one-cycle strobe, results hold until the next strobe.
// Ports   : clk_i, rst_n_i (async active-low), pwm_in_i; period_count_o, high_count_o,
//           valid_o, stuck_o, stuck_level_o.
// Macro   : PWM_CAPTURE_FILTER_EN enables the FILTER_LEN glitch filter in pwm_in_filter.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int FILTER_LEN = 4
)(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             pwm_in_i,
   output logic [CNT_W-1:0] period_count_o,
   output logic [CNT_W-1:0] high_count_o,
   output logic             valid_o,
   output logic             stuck_o,
   output logic             stuck_level_o
);

   if (TIMEOUT < 2 || FILTER_LEN < 1 || $clog2(TIMEOUT + 1) > CNT_W) begin : g_bad_param
      $error("pwm_capture: TIMEOUT must be 2..2**CNT_W-1 and FILTER_LEN >= 1");
   end

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic lvl;

`ifdef PWM_CAPTURE_FILTER_EN
   pwm_in_filter #(.FILTER_LEN(FILTER_LEN)) u_in_filter (
`else
   pwm_in_filter u_in_filter (
`endif
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .din_i   (pwm_in_i),
      .dout_o  (lvl)
   );

   // lvl_q is the level the counters see; prev_q is its one-cycle history.
   logic lvl_q, prev_q;
   logic rise;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             stuck_lvl_q, stuck_lvl_d;

   assign rise = lvl_q & ~prev_q;

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      period_d     = period_q;
      high_d       = high_q;
      valid_d      = 1'b0;
      stuck_d      = stuck_q;
      stuck_lvl_d  = stuck_lvl_q;

      unique case (state_q)
         SYNC: begin
            // Counting here only bounds the wait for a first edge; the value
            // is never reported, so high_cnt is kept at zero.
            if (rise) begin
               state_d      = MEASURE;
               period_cnt_d = ONE;
               high_cnt_d   = ONE;
            end else if (period_cnt_q == TO_VAL) begin
               stuck_d      = 1'b1;
               stuck_lvl_d  = lvl_q;
               period_cnt_d = '0;
               high_cnt_d   = '0;
            end else begin
               period_cnt_d = period_cnt_q + ONE;
               high_cnt_d   = '0;
            end
         end
         MEASURE: begin
            // Edge is tested before timeout so an edge on the TIMEOUT cycle
            // still reports a full period of TIMEOUT.
            if (rise) begin
               period_d     = period_cnt_q;
               high_d       = high_cnt_q;
               valid_d      = 1'b1;
               stuck_d      = 1'b0;
               period_cnt_d = ONE;
               high_cnt_d   = ONE;
            end else if (period_cnt_q == TO_VAL) begin
               state_d      = SYNC;
               stuck_d      = 1'b1;
               stuck_lvl_d  = lvl_q;
               period_cnt_d = '0;
               high_cnt_d   = '0;
            end else begin
               period_cnt_d = period_cnt_q + ONE;
               high_cnt_d   = high_cnt_q + (lvl_q ? ONE : '0);
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lvl_q        <= 1'b0;
         prev_q       <= 1'b0;
         state_q      <= SYNC;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         period_q     <= '0;
         high_q       <= '0;
         valid_q      <= 1'b0;
         stuck_q      <= 1'b0;
         stuck_lvl_q  <= 1'b0;
      end else begin
         lvl_q        <= lvl;
         prev_q       <= lvl_q;
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         period_q     <= period_d;
         high_q       <= high_d;
         valid_q      <= valid_d;
         stuck_q      <= stuck_d;
         stuck_lvl_q  <= stuck_lvl_d;
      end
   end

   assign period_count_o = period_q;
   assign high_count_o   = high_q;
   assign valid_o        = valid_q;
   assign stuck_o        = stuck_q;
   assign stuck_level_o  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose : directed self-checking bench for pwm_capture with TIMEOUT=100.
// Latency : expectations assume the default build (edge-to-VALID of 3 cycles).
// Backpr. : n/a.
module tb_pwm_capture;

   localparam int CNT_W      = 16;
   localparam int TIMEOUT    = 100;
   localparam int FILTER_LEN = 4;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             pwm   = 1'b0;
   logic [CNT_W-1:0] period_count;
   logic [CNT_W-1:0] high_count;
   logic             valid;
   logic             stuck;
   logic             stuck_level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int valid_cnt      = 0;
   int last_valid_cyc = -1;

   pwm_capture #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .pwm_in_i       (pwm),
      .period_count_o (period_count),
      .high_count_o   (high_count),
      .valid_o        (valid),
      .stuck_o        (stuck),
      .stuck_level_o  (stuck_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe observer, sampled on the falling edge.
   always @(negedge clk) begin
      if (valid) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
      end
   end

   // Each iteration drives a level, waits one rising edge and settles 1 time unit.
   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      pwm   = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (period_count !== 16'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_count); end
      total++; if (high_count !== 16'd0) begin bad++; $display("FAIL reset_high: got %0d want 0", high_count); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck: got %b want 0", stuck); end
      total++; if (stuck_level !== 1'b0) begin bad++; $display("FAIL reset_stuck_level: got %b want 0", stuck_level); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // 3 high / 5 low: first edge only arms, every later edge reports 8/3,
   // VALID 3 cycles after the edge that first samples the input high.
   task automatic test_periodic();
      int start;
      int vc0;
      drive(1'b0, 4);
      for (int k = 0; k < 5; k++) begin
         start = cyc;
         vc0   = valid_cnt;
         drive(1'b1, 3);
         drive(1'b0, 5);
         if (k == 0) begin
            total++; if (valid_cnt !== vc0) begin bad++; $display("FAIL first_edge_no_valid: got %0d strobes want 0", valid_cnt - vc0); end
         end else begin
            total++; if (valid_cnt !== vc0 + 1) begin bad++; $display("FAIL periodic_strobes[%0d]: got %0d want 1", k, valid_cnt - vc0); end
            total++; if (last_valid_cyc !== start + 4) begin bad++; $display("FAIL periodic_latency[%0d]: got cyc %0d want %0d", k, last_valid_cyc, start + 4); end
            total++; if (period_count !== 16'd8) begin bad++; $display("FAIL periodic_period[%0d]: got %0d want 8", k, period_count); end
            total++; if (high_count !== 16'd3) begin bad++; $display("FAIL periodic_high[%0d]: got %0d want 3", k, high_count); end
         end
      end
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL periodic_stuck: got %b want 0", stuck); end
   endtask

   task automatic test_reset_mid();
      int vc0;
      int start;
      drive(1'b1, 2);
      rst_n = 1'b0;
      pwm   = 1'b0;
      #2;
      total++; if (period_count !== 16'd0 || high_count !== 16'd0) begin bad++; $display("FAIL midreset_counts: got %0d/%0d want 0/0", period_count, high_count); end
      total++; if (valid !== 1'b0 || stuck !== 1'b0 || stuck_level !== 1'b0) begin bad++; $display("FAIL midreset_flags: got v%b s%b l%b want 000", valid, stuck, stuck_level); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vc0 = valid_cnt;
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 5);
      total++; if (valid_cnt !== vc0) begin bad++; $display("FAIL midreset_first_edge: got %0d strobes want 0", valid_cnt - vc0); end
      total++; if (period_count !== 16'd0) begin bad++; $display("FAIL midreset_hold: got %0d want 0", period_count); end
      start = cyc;
      drive(1'b1, 3);
      drive(1'b0, 5);
      total++; if (valid_cnt !== vc0 + 1) begin bad++; $display("FAIL midreset_second_edge: got %0d strobes want 1", valid_cnt - vc0); end
      total++; if (period_count !== 16'd8 || high_count !== 16'd3) begin bad++; $display("FAIL midreset_pair: got %0d/%0d want 8/3", period_count, high_count); end
      total++; if (last_valid_cyc !== start + 4) begin bad++; $display("FAIL midreset_latency: got cyc %0d want %0d", last_valid_cyc, start + 4); end
   endtask

   // Input held low after a measured period; STUCK sets when the counter
   // reaches TIMEOUT, then two further edges are needed to clear it.
   task automatic test_stuck_low();
      int vc0;
      int vc1;
      vc0 = valid_cnt;
      drive(1'b1, 3);
      drive(1'b0, TIMEOUT);
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL stuck_low_early: got %b want 0", stuck); end
      drive(1'b0, 1);
      total++; if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_low_set: got %b want 1", stuck); end
      total++; if (stuck_level !== 1'b0) begin bad++; $display("FAIL stuck_low_level: got %b want 0", stuck_level); end
      total++; if (period_count !== 16'd8 || high_count !== 16'd3) begin bad++; $display("FAIL stuck_low_hold: got %0d/%0d want 8/3", period_count, high_count); end
      total++; if (valid_cnt !== vc0 + 1) begin bad++; $display("FAIL stuck_low_strobes: got %0d want 1", valid_cnt - vc0); end
      vc1 = valid_cnt;
      drive(1'b1, 3);
      drive(1'b0, 5);
      total++; if (stuck !== 1'b1 || valid_cnt !== vc1) begin bad++; $display("FAIL stuck_low_rearm: got stuck %b strobes %0d want 1/0", stuck, valid_cnt - vc1); end
      drive(1'b1, 3);
      drive(1'b0, 5);
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL stuck_low_clear: got %b want 0", stuck); end
      total++; if (valid_cnt !== vc1 + 1 || period_count !== 16'd8 || high_count !== 16'd3) begin bad++; $display("FAIL stuck_low_resume: got %0d strobes %0d/%0d want 1 8/3", valid_cnt - vc1, period_count, high_count); end
   endtask

   task automatic test_stuck_high();
      int vc0;
      do_reset();
      vc0 = valid_cnt;
      drive(1'b1, TIMEOUT + 3);
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL stuck_high_early: got %b want 0", stuck); end
      drive(1'b1, 1);
      total++; if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_high_set: got %b want 1", stuck); end
      total++; if (stuck_level !== 1'b1) begin bad++; $display("FAIL stuck_high_level: got %b want 1", stuck_level); end
      drive(1'b1, 20);
      total++; if (valid_cnt !== vc0 || period_count !== 16'd0) begin bad++; $display("FAIL stuck_high_no_valid: got %0d strobes period %0d want 0/0", valid_cnt - vc0, period_count); end
   endtask

   // A period of exactly TIMEOUT is still reported; one cycle longer is stuck.
   task automatic test_timeout_edge();
      int vc0;
      int vc1;
      int start;
      do_reset();
      drive(1'b0, 4);
      drive(1'b1, 3);
      drive(1'b0, TIMEOUT - 3);
      vc0   = valid_cnt;
      start = cyc;
      drive(1'b1, 3);
      drive(1'b0, TIMEOUT - 3);
      total++; if (valid_cnt !== vc0 + 1 || last_valid_cyc !== start + 4) begin bad++; $display("FAIL edge_at_timeout_strobe: got %0d at cyc %0d want 1 at %0d", valid_cnt - vc0, last_valid_cyc, start + 4); end
      total++; if (period_count !== 16'(TIMEOUT) || high_count !== 16'd3) begin bad++; $display("FAIL edge_at_timeout_pair: got %0d/%0d want %0d/3", period_count, high_count, TIMEOUT); end
      total++; if (stuck !== 1'b0) begin bad++; $display("FAIL edge_at_timeout_stuck: got %b want 0", stuck); end
      vc1 = valid_cnt;
      drive(1'b1, 3);
      drive(1'b0, TIMEOUT - 2);
      drive(1'b1, 3);
      drive(1'b0, 5);
      total++; if (stuck !== 1'b1) begin bad++; $display("FAIL late_edge_stuck: got %b want 1", stuck); end
      total++; if (valid_cnt !== vc1 + 1 || period_count !== 16'(TIMEOUT)) begin bad++; $display("FAIL late_edge_hold: got %0d strobes period %0d want 1/%0d", valid_cnt - vc1, period_count, TIMEOUT); end
   endtask

   // 4-cycle pulse, 2-cycle glitch in the low phase, then another 4-cycle pulse.
   task automatic test_short_pulse();
      int vc0;
      do_reset();
      drive(1'b0, 10);
      drive(1'b1, 4);
      drive(1'b0, 10);
      vc0 = valid_cnt;
      drive(1'b1, 2);
      drive(1'b0, 10);
      drive(1'b1, 4);
      drive(1'b0, 10);
`ifdef PWM_CAPTURE_FILTER_EN
      total++; if (valid_cnt !== vc0 + 1) begin bad++; $display("FAIL filter_strobes: got %0d want 1", valid_cnt - vc0); end
      total++; if (period_count !== 16'd26 || high_count !== 16'd4) begin bad++; $display("FAIL filter_pair: got %0d/%0d want 26/4", period_count, high_count); end
`else
      total++; if (valid_cnt !== vc0 + 2) begin bad++; $display("FAIL glitch_strobes: got %0d want 2", valid_cnt - vc0); end
      total++; if (period_count !== 16'd12 || high_count !== 16'd2) begin bad++; $display("FAIL glitch_pair: got %0d/%0d want 12/2", period_count, high_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_reset_mid();
      test_stuck_low();
      test_stuck_high();
      test_timeout_edge();
      test_short_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
